// File: rtl/sdram_fifo_dispatcher.sv
// Pops commands and write data from FIFOs, runs one memory transaction at a time.
// Optional command checking is enabled by SDRAM_DISPATCH_ERRCHK_EN.
`ifndef SDRAM_CMD_FIFO_DATA_WIDTH
`define SDRAM_CMD_FIFO_DATA_WIDTH 36
`endif

module sdram_fifo_dispatcher #(
    parameter int MEM_ADDR_WIDTH = 23
) (
    input  logic                                  HCLK,
    input  logic                                  HRESETn,
    output logic                                  CFIFO_REN,
    input  logic [`SDRAM_CMD_FIFO_DATA_WIDTH-1:0] CFIFO_RDATA,
    input  logic                                  CFIFO_REMPTY,
    output logic                                  WFIFO_REN,
    input  logic [31:0]                           WFIFO_RDATA,
    input  logic                                  WFIFO_REMPTY,
    output logic                                  RFIFO_WEN,
    output logic [31:0]                           RFIFO_WDATA,
    input  logic                                  RFIFO_WFULL,
    output logic                                  MEM_REQ,
    output logic                                  MEM_WRITE,
    output logic [MEM_ADDR_WIDTH-1:0]             MEM_ADDR,
    output logic [3:0]                            MEM_BE,
    output logic [31:0]                           MEM_WDATA,
    input  logic                                  MEM_ACK,
    input  logic                                  MEM_RVALID,
    input  logic [31:0]                           MEM_RDATA,
    output logic                                  CMD_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA_WAIT,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_RF_PUSH,
        S_DROP_WR
    } state_t;

    state_t                                 state_q, state_d;
    logic [`SDRAM_CMD_FIFO_DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [31:0]                            rdata_q, rdata_d;
    logic [3:0]                             be;
    logic                                   unused_bits;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SDRAM_DISPATCH_ERRCHK_EN
    logic cmd_err_q, cmd_err_d;
    logic bad_cmd;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cmd_err_q <= 1'b0;
        else          cmd_err_q <= cmd_err_d;
    end

    // Misaligned or oversized accesses are never sent to the core.
    always_comb begin
        bad_cmd = 1'b0;
        if (CFIFO_RDATA[34:32] > 3'd2)
            bad_cmd = 1'b1;
        else if (CFIFO_RDATA[34:32] == 3'd2 && CFIFO_RDATA[1:0] != 2'b00)
            bad_cmd = 1'b1;
        else if (CFIFO_RDATA[34:32] == 3'd1 && CFIFO_RDATA[0])
            bad_cmd = 1'b1;
    end

    assign CMD_ERR = cmd_err_q;
`else
    assign CMD_ERR = 1'b0;
`endif

    always_comb begin
        case (cmd_q[34:32])
            3'd0:    be = 4'b0001 << cmd_q[1:0];
            3'd1:    be = cmd_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rdata_d   = rdata_q;
        CFIFO_REN = 1'b0;
        WFIFO_REN = 1'b0;
        RFIFO_WEN = 1'b0;
        MEM_REQ   = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_WDATA = '0;
`ifdef SDRAM_DISPATCH_ERRCHK_EN
        cmd_err_d = cmd_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!CFIFO_REMPTY) begin
                    CFIFO_REN = 1'b1;
                    cmd_d     = CFIFO_RDATA;
`ifdef SDRAM_DISPATCH_ERRCHK_EN
                    if (bad_cmd) begin
                        cmd_err_d = 1'b1;
                        if (CFIFO_RDATA[35]) begin
                            state_d = S_DROP_WR;
                        end else begin
                            rdata_d = '0;
                            state_d = S_RF_PUSH;
                        end
                    end else
`endif
                    if (CFIFO_RDATA[35])
                        state_d = WFIFO_REMPTY ? S_WDATA_WAIT : S_WR_REQ;
                    else
                        state_d = S_RD_REQ;
                end
            end
            S_WDATA_WAIT: begin
                if (!WFIFO_REMPTY) state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                MEM_REQ   = 1'b1;
                MEM_WRITE = 1'b1;
                MEM_WDATA = WFIFO_RDATA;
                if (MEM_ACK) begin
                    WFIFO_REN = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_REQ: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (MEM_RVALID) begin
                    rdata_d = MEM_RDATA;
                    state_d = S_RF_PUSH;
                end
            end
            S_RF_PUSH: begin
                RFIFO_WEN = ~RFIFO_WFULL;
                if (!RFIFO_WFULL) state_d = S_IDLE;
            end
            S_DROP_WR: begin
                if (!WFIFO_REMPTY) begin
                    WFIFO_REN = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and enables are zero whenever no request is presented.
    assign MEM_ADDR    = MEM_REQ ? cmd_q[MEM_ADDR_WIDTH+1:2] : '0;
    assign MEM_BE      = MEM_REQ ? be : 4'b0000;
    assign RFIFO_WDATA = rdata_q;

    assign unused_bits = ^{cmd_q[35], cmd_q[31:MEM_ADDR_WIDTH+2]};

endmodule

// File: tb/tb_sdram_fifo_dispatcher.sv
// Directed bench for sdram_fifo_dispatcher.
// FWFT FIFO models; optional ERRCHK build.
`timescale 1ns/1ps

module tb_sdram_fifo_dispatcher;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        CFIFO_REN;
  logic [35:0] CFIFO_RDATA;
  logic        CFIFO_REMPTY;
  logic        WFIFO_REN;
  logic [31:0] WFIFO_RDATA;
  logic        WFIFO_REMPTY;
  logic        RFIFO_WEN;
  logic [31:0] RFIFO_WDATA;
  logic        RFIFO_WFULL = 1'b0;
  logic        MEM_REQ;
  logic        MEM_WRITE;
  logic [22:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;
  logic        CMD_ERR;

  int checks = 0;
  int failures = 0;

  logic [35:0] cmem [8];
  logic [31:0] wmem [8];
  logic [3:0]  ch = '0, ct = '0;
  logic [3:0]  wh = '0, wt = '0;
  int          wpops = 0;
  int          rn = 0;
  int          mn = 0;
  logic [31:0] rlog [16];
  logic [59:0] mlog [16];

  assign CFIFO_RDATA  = cmem[ch[2:0]];
  assign CFIFO_REMPTY = (ch == ct);
  assign WFIFO_RDATA  = wmem[wh[2:0]];
  assign WFIFO_REMPTY = (wh == wt);

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (CFIFO_REN && !CFIFO_REMPTY)
      ch <= ch + 4'd1;
    if (WFIFO_REN && !WFIFO_REMPTY) begin
      wh    <= wh + 4'd1;
      wpops <= wpops + 1;
    end
    if (RFIFO_WEN) begin
      rlog[rn[3:0]] <= RFIFO_WDATA;
      rn            <= rn + 1;
    end
    if (MEM_REQ && MEM_ACK) begin
      mlog[mn[3:0]] <= {MEM_WRITE, MEM_ADDR,
                        MEM_BE, MEM_WDATA};
      mn            <= mn + 1;
    end
  end

  sdram_fifo_dispatcher dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .CFIFO_REN    (CFIFO_REN),
    .CFIFO_RDATA  (CFIFO_RDATA),
    .CFIFO_REMPTY (CFIFO_REMPTY),
    .WFIFO_REN    (WFIFO_REN),
    .WFIFO_RDATA  (WFIFO_RDATA),
    .WFIFO_REMPTY (WFIFO_REMPTY),
    .RFIFO_WEN    (RFIFO_WEN),
    .RFIFO_WDATA  (RFIFO_WDATA),
    .RFIFO_WFULL  (RFIFO_WFULL),
    .MEM_REQ      (MEM_REQ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_BE       (MEM_BE),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_ACK      (MEM_ACK),
    .MEM_RVALID   (MEM_RVALID),
    .MEM_RDATA    (MEM_RDATA),
    .CMD_ERR      (CMD_ERR)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_cmd(
    input logic        w,
    input logic [2:0]  sz,
    input logic [31:0] a
  );
    cmem[ct[2:0]] = {w, sz, a};
    ct = ct + 4'd1;
  endtask

  task automatic push_wd(input logic [31:0] d);
    wmem[wt[2:0]] = d;
    wt = wt + 4'd1;
  endtask

  initial begin
    int mbase;
    int rbase;
    int wbase;
    logic done;

    #2;
    chk("rst_mem_req", MEM_REQ, 1'b0);
    chk("rst_cfifo_ren", CFIFO_REN, 1'b0);
    chk("rst_rfifo_wen", RFIFO_WEN, 1'b0);
    chk("rst_rdata", RFIFO_WDATA, 32'h0);
    chk("rst_cmd_err", CMD_ERR, 1'b0);
    tick();
    HRESETn = 1'b1;
    tick();

    push_cmd(1'b1, 3'd2, 32'h0000_0010);
    push_wd(32'hDEAD_BEEF);
    #1;
    chk("wr_cfifo_ren", CFIFO_REN, 1'b1);
    chk("wr_req_early", MEM_REQ, 1'b0);
    tick();
    chk("wr_req", MEM_REQ, 1'b1);
    chk("wr_write", MEM_WRITE, 1'b1);
    chk("wr_addr", MEM_ADDR, 23'h4);
    chk("wr_be", MEM_BE, 4'b1111);
    chk("wr_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    chk("wr_no_pop", WFIFO_REN, 1'b0);
    tick();
    tick();
    chk("wr_addr_stable", MEM_ADDR, 23'h4);
    MEM_ACK = 1'b1;
    #1;
    chk("wr_pop_on_ack", WFIFO_REN, 1'b1);
    tick();
    MEM_ACK = 1'b0;
    #1;
    chk("wr_req_done", MEM_REQ, 1'b0);
    chk("wr_pop_count", wpops, 1);

    push_cmd(1'b0, 3'd0, 32'h0000_0023);
    tick();
    chk("rd_req", MEM_REQ, 1'b1);
    chk("rd_write", MEM_WRITE, 1'b0);
    chk("rd_be", MEM_BE, 4'b1000);
    chk("rd_addr", MEM_ADDR, 23'h8);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    #1;
    chk("rd_wait_req", MEM_REQ, 1'b0);
    tick();
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h1234_5678;
    tick();
    MEM_RVALID = 1'b0;
    #1;
    chk("rd_push", RFIFO_WEN, 1'b1);
    chk("rd_push_data", RFIFO_WDATA,
        32'h1234_5678);
    tick();
    chk("rd_push_once", RFIFO_WEN, 1'b0);
    chk("rd_push_count", rn, 1);

    push_cmd(1'b0, 3'd1, 32'h0000_0022);
    tick();
    chk("bp_be", MEM_BE, 4'b1100);
    chk("bp_addr", MEM_ADDR, 23'h8);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK     = 1'b0;
    MEM_RVALID  = 1'b1;
    MEM_RDATA   = 32'h55AA_33CC;
    RFIFO_WFULL = 1'b1;
    tick();
    MEM_RVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_wen", RFIFO_WEN, 1'b0);
      chk("bp_hold_data", RFIFO_WDATA,
          32'h55AA_33CC);
      tick();
    end
    RFIFO_WFULL = 1'b0;
    #1;
    chk("bp_release", RFIFO_WEN, 1'b1);
    tick();
    chk("bp_single", RFIFO_WEN, 1'b0);
    chk("bp_count", rn, 2);
    chk("bp_logged", rlog[1], 32'h55AA_33CC);

    push_cmd(1'b1, 3'd1, 32'h0000_0040);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wwait_no_req", MEM_REQ, 1'b0);
      tick();
    end
    push_wd(32'h0000_A5A5);
    #1;
    chk("wwait_still_idle", MEM_REQ, 1'b0);
    tick();
    chk("wwait_req", MEM_REQ, 1'b1);
    chk("wwait_be", MEM_BE, 4'b0011);
    chk("wwait_addr", MEM_ADDR, 23'h10);
    chk("wwait_wdata", MEM_WDATA, 32'h0000_A5A5);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    #1;
    chk("wwait_pops", wpops, 2);

    mbase = mn;
    rbase = rn;
    wbase = wpops;
    push_cmd(1'b1, 3'd2, 32'h0000_0100);
    push_cmd(1'b0, 3'd2, 32'h0000_0200);
    push_cmd(1'b1, 3'd0, 32'h0000_0301);
    push_wd(32'h1111_1111);
    push_wd(32'h0000_0022);
    MEM_ACK    = 1'b1;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'hCAFE_0001;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = (mn == mbase + 3) &&
             (rn == rbase + 1);
    end
    MEM_ACK    = 1'b0;
    MEM_RVALID = 1'b0;
    chk("b2b_complete", done, 1'b1);
    chk("b2b_txn0", mlog[mbase[3:0]],
        {1'b1, 23'h40, 4'b1111, 32'h1111_1111});
    chk("b2b_txn1", mlog[mbase[3:0] + 4'd1],
        {1'b0, 23'h80, 4'b1111, 32'h0});
    chk("b2b_txn2", mlog[mbase[3:0] + 4'd2],
        {1'b1, 23'hC0, 4'b0010, 32'h22});
    chk("b2b_rdata", rlog[rbase[3:0]],
        32'hCAFE_0001);
    chk("b2b_pops", wpops, wbase + 2);
    chk("b2b_cfifo_empty", CFIFO_REMPTY, 1'b1);

`ifdef SDRAM_DISPATCH_ERRCHK_EN
    mbase = mn;
    wbase = wpops;
    push_cmd(1'b1, 3'd2, 32'h0000_0002);
    push_wd(32'h0000_0099);
    tick();
    chk("err_wr_flag", CMD_ERR, 1'b1);
    chk("err_wr_no_req", MEM_REQ, 1'b0);
    chk("err_wr_drop", WFIFO_REN, 1'b1);
    tick();
    chk("err_wr_pops", wpops, wbase + 1);
    push_cmd(1'b0, 3'd3, 32'h0000_0000);
    tick();
    chk("err_rd_no_req", MEM_REQ, 1'b0);
    chk("err_rd_push", RFIFO_WEN, 1'b1);
    chk("err_rd_zero", RFIFO_WDATA, 32'h0);
    tick();
    chk("err_no_mem_txn", mn, mbase);
    chk("err_sticky", CMD_ERR, 1'b1);
`else
    chk("noerr_flag", CMD_ERR, 1'b0);
`endif

    push_cmd(1'b0, 3'd2, 32'h0000_0400);
    tick();
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_req", MEM_REQ, 1'b0);
    chk("arst_be", MEM_BE, 4'b0000);
    chk("arst_wen", RFIFO_WEN, 1'b0);
    chk("arst_rdata", RFIFO_WDATA, 32'h0);
    chk("arst_cmd_err", CMD_ERR, 1'b0);
    rbase = rn;
    tick();
    HRESETn    = 1'b1;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h0000_0BAD;
    tick();
    MEM_RVALID = 1'b0;
    #1;
    chk("arst_idle_wen", RFIFO_WEN, 1'b0);
    chk("arst_idle_req", MEM_REQ, 1'b0);
    tick();
    chk("arst_no_push", rn, rbase);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_fifo_dispatcher.md
SDRAM_FIFO_DISPATCHER -- requirements
Module: sdram_fifo_dispatcher

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 23, the word-address width presented to the memory core.
REQ-002 SHALL have port HCLK  in  1  the single clock; reset is asynchronous and active-low.
REQ-003 SHALL have port HRESETn  in  1  the asynchronous active-low reset.
REQ-004 SHALL have ports CFIFO_REN out 1, CFIFO_RDATA in `SDRAM_CMD_FIFO_DATA_WIDTH (36), CFIFO_REMPTY in 1: the command FIFO reader; bits [31:0] address, [34:32] size, [35] write.
REQ-005 SHALL have ports WFIFO_REN out 1, WFIFO_RDATA in 32, WFIFO_REMPTY in 1: the write-data FIFO reader.
REQ-006 SHALL have ports RFIFO_WEN out 1, RFIFO_WDATA out 32, RFIFO_WFULL in 1: the read-data FIFO writer.
REQ-007 SHALL have memory-core ports MEM_REQ out 1, MEM_WRITE out 1, MEM_ADDR out MEM_ADDR_WIDTH, MEM_BE out 4, MEM_WDATA out 32, MEM_ACK in 1, MEM_RVALID in 1, MEM_RDATA in 32.
REQ-008 SHALL have port CMD_ERR out 1: sticky command-error flag.

Function
REQ-009 SHALL treat all FIFOs as first-word-fall-through: RDATA valid while REMPTY=0; a REN pulse pops one entry on that edge.
REQ-010 SHALL implement states S_IDLE, S_WDATA_WAIT, S_WR_REQ, S_RD_REQ, S_RD_WAIT, S_RF_PUSH, S_DROP_WR.
REQ-011 S_IDLE: when CFIFO_REMPTY=0, SHALL assert CFIFO_REN for one cycle and latch CFIFO_RDATA into the command register in the same cycle.
REQ-012 S_IDLE exit on a pop: write with WFIFO_REMPTY=1 -> S_WDATA_WAIT; write with WFIFO_REMPTY=0 -> S_WR_REQ; read -> S_RD_REQ.
REQ-013 S_WDATA_WAIT SHALL go to S_WR_REQ in the first cycle with WFIFO_REMPTY=0.
REQ-014 S_WR_REQ: MEM_REQ=1, MEM_WRITE=1, MEM_WDATA=WFIFO_RDATA; on MEM_ACK=1, WFIFO_REN=1 in that cycle -> S_IDLE.
REQ-015 S_RD_REQ: MEM_REQ=1, MEM_WRITE=0; on MEM_ACK=1 -> S_RD_WAIT.
REQ-016 S_RD_WAIT: MEM_RVALID ignored in all other states; on MEM_RVALID=1, latch MEM_RDATA -> S_RF_PUSH.
REQ-017 S_RF_PUSH: RFIFO_WEN = ~RFIFO_WFULL; RFIFO_WDATA = latched data; -> S_IDLE on the cycle RFIFO_WEN=1; holds while full.
REQ-018 MEM_ADDR = cmd addr[MEM_ADDR_WIDTH+1:2]; MEM_ADDR, MEM_BE, MEM_WRITE SHALL stay stable while MEM_REQ=1 until MEM_ACK.
REQ-019 MEM_BE: size 0 -> 4'b0001 << addr[1:0]; size 1 -> addr[1] ? 4'b1100 : 4'b0011; size >= 2 -> 4'b1111.
REQ-020 Exactly one memory transaction SHALL be in flight; command order SHALL be preserved; write-data entries popped 1:1 with write commands.
REQ-021 Minimum latency: CFIFO not-empty to MEM_REQ = 1 cycle; MEM_RVALID to RFIFO_WEN = 1 cycle when not full.
REQ-022 MEM_REQ, WFIFO_REN, RFIFO_WEN SHALL be deasserted in every state except those listed above.

Reset
REQ-023 On HRESETn=0, SHALL asynchronously enter S_IDLE; all outputs 0; command and read-data registers 0; CMD_ERR 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction; the FIFOs and memory core SHALL be reset by the same HRESETn.

Configuration
REQ-025 Macro SDRAM_DISPATCH_ERRCHK_EN defined: a command with size > 2, size 2 with addr[1:0] != 0, or size 1 with addr[0]=1 SHALL be rejected, with no MEM_REQ and CMD_ERR set until reset.
REQ-026 With the macro: a rejected write SHALL go to S_DROP_WR, pop one WFIFO entry when non-empty, then return to S_IDLE; a rejected read SHALL go to S_RF_PUSH with data 32'h0.
REQ-027 Macro undefined: no checking; every command is executed per REQ-019; CMD_ERR is tied 0.

Verification
REQ-028 Write: CFIFO {W=1,size=2,addr=0x0000_0010}, WFIFO 0xDEADBEEF, ACK after 3 cycles -> MEM_ADDR=0x4, MEM_BE=1111, MEM_WDATA=0xDEADBEEF, one WFIFO_REN on the ACK cycle.
REQ-029 Read: CFIFO {W=0,size=0,addr=0x23}, RVALID with 0x12345678 -> MEM_BE=1000, RFIFO_WEN one cycle, RFIFO_WDATA=0x12345678.
REQ-030 Backpressure: RFIFO_WFULL=1 for 5 cycles after RVALID -> RFIFO_WEN held 0, data held, single push once full drops.
REQ-031 Write command with WFIFO empty for 4 cycles -> no MEM_REQ until WFIFO_REMPTY=0; 3 back-to-back mixed commands complete in order.
REQ-032 ERRCHK_EN: write {size=2,addr=0x2} -> no MEM_REQ, one WFIFO pop, CMD_ERR=1; read {size=3} -> RFIFO_WDATA=0.
REQ-033 Reset asserted in S_RD_WAIT -> all outputs 0 asynchronously; state S_IDLE after release.
